// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and beat-count helper for the polynomial
// serialization path.
package kyber_pkg;

    localparam int Q = 3329;
    localparam int N = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Output beats per polynomial for a given coefficient width and bus width.
    function automatic int calc_beats(input int d, input int dwidth);
        return (N * d) / dwidth;
    endfunction

endpackage

// File: rtl/poly_byte_encode_if.sv
// Sink (16-bit coefficient) and source (DWIDTH-bit packed) AXI4-Stream bundle.
// The slave modport is the encoder's view; master is the environment's view.
interface poly_byte_encode_if #(
    parameter int DWIDTH     = 256,
    parameter int KEEP_WIDTH = DWIDTH / 8
);
    logic [15:0]           t_data_i;
    logic                  t_valid_i;
    logic                  t_last_i;
    logic [1:0]            t_keep_i;
    logic                  t_ready_o;
    logic [DWIDTH-1:0]     t_data_o;
    logic                  t_valid_o;
    logic                  t_last_o;
    logic [KEEP_WIDTH-1:0] t_keep_o;
    logic                  t_ready_i;

    modport slave (
        input  t_data_i, t_valid_i, t_last_i, t_keep_i, t_ready_i,
        output t_ready_o, t_data_o, t_valid_o, t_last_o, t_keep_o
    );

    modport master (
        output t_data_i, t_valid_i, t_last_i, t_keep_i, t_ready_i,
        input  t_ready_o, t_data_o, t_valid_o, t_last_o, t_keep_o
    );
endinterface

// File: rtl/poly_bit_packer.sv
// Bit accumulator: appends D-bit coefficients above the current occupancy and
// shifts out DWIDTH bits at a time. Shift is applied before append so a
// same-cycle coefficient lands after the emitted beat.
module poly_bit_packer #(
    parameter int DWIDTH = 256,
    parameter int D      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_append,
    input  logic [D-1:0]      i_coeff,
    input  logic              i_shift,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_full
);
    localparam int AW = DWIDTH + D;
    localparam int BW = $clog2(DWIDTH + D);

    logic [AW-1:0] r_acc, w_base, w_acc_nxt;
    logic [BW-1:0] r_bits, w_base_bits, w_bits_nxt;

    // Next accumulator: optional shift-out, then optional append.
    always_comb begin
        w_base      = i_shift ? (r_acc >> DWIDTH) : r_acc;
        w_base_bits = i_shift ? (r_bits - BW'(DWIDTH)) : r_bits;
        w_acc_nxt   = w_base;
        w_bits_nxt  = w_base_bits;
        if (i_append) begin
            w_acc_nxt  = w_base | (AW'(i_coeff) << w_base_bits);
            w_bits_nxt = w_base_bits + BW'(D);
        end
    end

    // Accumulator state; clear wipes any partial polynomial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_bits <= '0;
        end else if (i_clear) begin
            r_acc  <= '0;
            r_bits <= '0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_bits <= w_bits_nxt;
        end
    end

    assign o_data = r_acc[DWIDTH-1:0];
    assign o_full = (r_bits >= BW'(DWIDTH));

endmodule

// File: rtl/poly_byte_encode.sv
// ByteEncode_D streaming stage: packs the low D bits of 256 coefficients
// LSB-first into DWIDTH-bit little-endian beats.
// Optional: define POLY_ENCODE_RANGE_CHECK_EN to flag out-of-range
// coefficients on err_o (low D bits are still packed).
module poly_byte_encode
    import kyber_pkg::*;
#(
    parameter int DWIDTH     = 256,
    parameter int KEEP_WIDTH = DWIDTH / 8,
    parameter int D          = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               done,
    output logic               err_o,
    poly_byte_encode_if.slave  s
);
    localparam int BEATS = calc_beats(D, DWIDTH);
    localparam int CW    = $clog2(N + 1);
    localparam int BCW   = $clog2(BEATS + 1);

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_coeff_cnt;
    logic [BCW-1:0]    r_beat_cnt;
    logic              r_err;
    logic              r_valid;
    logic              r_last;
    logic [DWIDTH-1:0] r_data;

    logic              w_start_acc, w_sink_rdy, w_sink_hs, w_emit;
    logic              w_out_hs, w_final, w_last_exp, w_range_bad, w_bad;
    logic              w_full;
    logic [DWIDTH-1:0] w_acc_lo;
    logic              w_unused;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_sink_rdy  = (r_state == RUN) && (r_coeff_cnt < CW'(N)) && !w_full;
    assign w_sink_hs   = w_sink_rdy && s.t_valid_i;
    assign w_emit      = (r_state == RUN) && w_full && (!r_valid || s.t_ready_i);
    assign w_out_hs    = r_valid && s.t_ready_i;
    assign w_final     = w_out_hs && r_last;
    assign w_last_exp  = (r_coeff_cnt == CW'(N - 1));

`ifdef POLY_ENCODE_RANGE_CHECK_EN
    localparam logic [16:0] LIMIT = 17'((D == 12) ? Q : (1 << D));
    assign w_range_bad = ({1'b0, s.t_data_i} >= LIMIT);
`else
    assign w_range_bad = 1'b0;
`endif

    assign w_bad    = w_sink_hs && ((s.t_last_i != w_last_exp) || w_range_bad);
    assign w_unused = ^{s.t_keep_i, s.t_data_i[15:D]};

    poly_bit_packer #(.DWIDTH(DWIDTH), .D(D)) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_start_acc),
        .i_append (w_sink_hs),
        .i_coeff  (s.t_data_i[D-1:0]),
        .i_shift  (w_emit),
        .o_data   (w_acc_lo),
        .o_full   (w_full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state; unknown encodings fall back to IDLE.
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = start ? RUN : IDLE;
            RUN:     w_state_nxt = w_final ? DONE : RUN;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Coefficient and beat counters, restarted by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coeff_cnt <= '0;
            r_beat_cnt  <= '0;
        end else if (w_start_acc) begin
            r_coeff_cnt <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_sink_hs) r_coeff_cnt <= r_coeff_cnt + 1'b1;
            if (w_emit)    r_beat_cnt  <= r_beat_cnt + 1'b1;
        end
    end

    // Sticky error: framing mismatch or (optionally) out-of-range coefficient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_err <= 1'b0;
        else if (w_start_acc) r_err <= 1'b0;
        else if (w_bad)       r_err <= 1'b1;
    end

    // Output beat register: load on emit, hold while stalled, drop after handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_start_acc) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_emit) begin
            r_data  <= w_acc_lo;
            r_valid <= 1'b1;
            r_last  <= (r_beat_cnt == BCW'(BEATS - 1));
        end else if (w_out_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign s.t_ready_o = w_sink_rdy;
    assign s.t_data_o  = r_data;
    assign s.t_valid_o = r_valid;
    assign s.t_last_o  = r_last;
    assign s.t_keep_o  = {KEEP_WIDTH{r_valid}};
    assign done        = (r_state == DONE);
    assign err_o       = r_err;

endmodule

// File: tb/tb_poly_byte_encode.sv
// Bench for poly_byte_encode: a bit-level ByteEncode model feeds an expected
// beat queue that a single monitor checks every cycle (D=12), plus a D=1
// instance checked directly.
module tb_poly_byte_encode;

`ifdef POLY_ENCODE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    localparam int BEATS = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, done_a, err_a;
    logic start_b = 1'b0, done_b, err_b;

    always #5 clk = ~clk;

    poly_byte_encode_if #(.DWIDTH(256), .KEEP_WIDTH(32)) ifa ();
    poly_byte_encode_if #(.DWIDTH(256), .KEEP_WIDTH(32)) ifb ();

    poly_byte_encode #(.DWIDTH(256), .KEEP_WIDTH(32), .D(12)) u_d12 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .done(done_a), .err_o(err_a), .s(ifa)
    );
    poly_byte_encode #(.DWIDTH(256), .KEEP_WIDTH(32), .D(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .done(done_b), .err_o(err_b), .s(ifb)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0]  coef [256];
    logic [255:0] exp_q [$];
    logic [255:0] first_beat;
    logic [255:0] held;
    int  beat_idx  = 0;
    int  rdy_pct   = 100;
    int  err_idx   = -1;
    bit  stalled   = 0;
    bit  done_pend = 0;
    bit  done_seen = 0;
    bit  abort     = 0;
    bit  mon_en    = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected beats straight from the encoding rule: global bit g = i*12 + j.
    task automatic build_exp();
        logic [255:0] b;
        int g;
        exp_q.delete();
        for (int k = 0; k < BEATS; k++) begin
            for (int x = 0; x < 256; x++) begin
                g    = k * 256 + x;
                b[x] = coef[g / 12][g % 12];
            end
            exp_q.push_back(b);
        end
    endtask

    // Source backpressure.
    initial begin
        ifa.t_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            ifa.t_ready_i = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor for the D=12 instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (start_a) begin
                beat_idx  = 0;
                done_seen = 0;
                done_pend = 0;
            end
            chk("keep", 256'(ifa.t_keep_o), ifa.t_valid_o ? 256'hFFFF_FFFF : 256'd0);
            chk("done", 256'(done_a), 256'(done_pend));
            if (done_a) done_seen = 1;
            done_pend = 0;
            if (ifa.t_valid_o) begin
                if (stalled) chk("stable", ifa.t_data_o, held);
                if (ifa.t_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 256'(beat_idx), 256'(BEATS));
                        beat_idx++;
                    end else begin
                        chk($sformatf("beat%0d", beat_idx), ifa.t_data_o, exp_q.pop_front());
                        chk("last", 256'(ifa.t_last_o), 256'(beat_idx == BEATS - 1));
                        if (beat_idx == 0) first_beat = ifa.t_data_o;
                        if (beat_idx == BEATS - 1) done_pend = 1;
                        beat_idx++;
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held    = ifa.t_data_o;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        start_a = 1'b1;
        @(negedge clk);
        chk("ready_idle", 256'(ifa.t_ready_o), 256'd0);
        @(posedge clk); #1;
        start_a = 1'b0;
        @(negedge clk);
        chk("ready_rise", 256'(ifa.t_ready_o), 256'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_poly(input int extra_last, input int gap_pct);
        bit hs;
        for (int i = 0; i < 256 && !abort; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                ifa.t_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            ifa.t_valid_i = 1'b1;
            ifa.t_data_i  = coef[i];
            ifa.t_last_i  = (i == 255) || (i == extra_last);
            ifa.t_keep_i  = 2'b11;
            hs = 0;
            for (int c = 0; c < 2000 && !hs && !abort; c++) begin
                @(negedge clk);
                hs = ifa.t_ready_o;
                @(posedge clk); #1;
            end
            if (!hs && !abort) begin
                n_vec++; n_err++;
                $display("FAIL sink_timeout: coefficient %0d never accepted", i);
                break;
            end
            if (i == err_idx) chk("err_next", 256'(err_a), 256'(RC));
        end
        ifa.t_valid_i = 1'b0;
        ifa.t_last_i  = 1'b0;
        if (!abort) begin
            @(negedge clk);
            chk("ready_after_last", 256'(ifa.t_ready_o), 256'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_poly(input int extra_last, input int gap, input int rdy, input bit exp_err);
        rdy_pct = rdy;
        build_exp();
        do_start();
        send_poly(extra_last, gap);
        for (int c = 0; c < 5000 && !done_seen; c++) @(negedge clk);
        chk("done_seen", 256'(done_seen), 256'd1);
        chk("beat_count", 256'(beat_idx), 256'(BEATS));
        chk("queue_empty", 256'(exp_q.size()), 256'd0);
        chk("err", 256'(err_a), 256'(exp_err));
        rdy_pct = 100;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) coef[i] = 16'($urandom_range(3328));
    endtask

    initial begin
        int cnt;
        bit hs;
        ifa.t_valid_i = 0; ifa.t_data_i = 0; ifa.t_last_i = 0; ifa.t_keep_i = 2'b11;
        ifb.t_valid_i = 0; ifb.t_data_i = 0; ifb.t_last_i = 0; ifb.t_keep_i = 2'b11;
        ifb.t_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 256'(ifa.t_ready_o), 256'd0);
        chk("rst_valid", 256'(ifa.t_valid_o), 256'd0);
        chk("rst_last",  256'(ifa.t_last_o),  256'd0);
        chk("rst_keep",  256'(ifa.t_keep_o),  256'd0);
        chk("rst_data",  ifa.t_data_o,        256'd0);
        chk("rst_done",  256'(done_a),        256'd0);
        chk("rst_err",   256'(err_a),         256'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Constant 0xABC: bytes BC CA AB repeating.
        for (int i = 0; i < 256; i++) coef[i] = 16'hABC;
        run_poly(-1, 0, 100, 1'b0);
        chk("abc_b0",  256'(first_beat[7:0]),     256'h BC);
        chk("abc_b1",  256'(first_beat[15:8]),    256'h CA);
        chk("abc_b2",  256'(first_beat[23:16]),   256'h AB);
        chk("abc_b31", 256'(first_beat[255:248]), 256'h CA);

        // Ramp coefficients.
        for (int i = 0; i < 256; i++) coef[i] = 16'(i);
        run_poly(-1, 0, 100, 1'b0);
        chk("ramp_b0_7", 256'(first_beat[63:0]), 256'h5004003002001000);

        // Out-of-range value 3329 at index 7.
        coef[7] = 16'd3329;
        err_idx = 7;
        run_poly(-1, 0, 100, RC);
        err_idx = -1;
        chk("q_packed", 256'(first_beat[95:84]), 256'h D01);

        // Spurious t_last_i on coefficient 99.
        fill_random();
        run_poly(99, 0, 100, 1'b1);

        // Same random polynomial, free-flowing then heavily stalled.
        fill_random();
        run_poly(-1, 0, 100, 1'b0);
        run_poly(-1, 30, 50, 1'b0);

        // Reset after beat 5, then a clean polynomial.
        fill_random();
        build_exp();
        do_start();
        abort = 0;
        fork
            send_poly(-1, 0);
            begin
                for (int c = 0; c < 3000 && beat_idx < 6; c++) @(negedge clk);
                chk("reach_beat6", 256'(beat_idx >= 6), 256'd1);
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                chk("mid_rst_ready", 256'(ifa.t_ready_o), 256'd0);
                chk("mid_rst_valid", 256'(ifa.t_valid_o), 256'd0);
                chk("mid_rst_last",  256'(ifa.t_last_o),  256'd0);
                chk("mid_rst_keep",  256'(ifa.t_keep_o),  256'd0);
                chk("mid_rst_data",  ifa.t_data_o,        256'd0);
                chk("mid_rst_done",  256'(done_a),        256'd0);
                abort = 1;
            end
        join
        abort = 0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill_random();
        run_poly(-1, 0, 100, 1'b0);

        // D=1: 256 ones make a single all-ones beat.
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        ifb.t_valid_i = 1'b1;
        ifb.t_data_i  = 16'd1;
        cnt = 0;
        for (int c = 0; c < 2000 && cnt < 256; c++) begin
            ifb.t_last_i = (cnt == 255);
            @(negedge clk);
            hs = ifb.t_ready_o;
            @(posedge clk); #1;
            if (hs) cnt++;
        end
        ifb.t_valid_i = 1'b0;
        ifb.t_last_i  = 1'b0;
        chk("d1_count", 256'(cnt), 256'd256);
        hs = 0;
        for (int c = 0; c < 20 && !hs; c++) begin
            @(negedge clk);
            hs = ifb.t_valid_o;
        end
        chk("d1_valid", 256'(ifb.t_valid_o), 256'd1);
        chk("d1_data",  ifb.t_data_o, {256{1'b1}});
        chk("d1_last",  256'(ifb.t_last_o), 256'd1);
        chk("d1_keep",  256'(ifb.t_keep_o), 256'hFFFF_FFFF);
        @(negedge clk);
        chk("d1_done",  256'(done_b), 256'd1);
        chk("d1_err",   256'(err_b),  256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
